axi4_lite_cmd_master: RTL

AXI4_LITE_CMD_MASTER -- requirements
Module: axi4_lite_cmd_master

---
 rtl/axi4_lite_pkg.sv | 19 +
 rtl/axi4_lite_timeout.sv | 42 ++++
 rtl/axi4_lite_cmd_master.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the command-master state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] AXI_RESP_OK     = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5,
    ST_DRAIN = 3'd6
  } state_t;

endpackage

// File: rtl/axi4_lite_timeout.sv
// Response-wait watchdog: counts enabled cycles after a clear and flags when TIMEOUT is reached.
module axi4_lite_timeout #(
  parameter int TIMEOUT = 1024
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A zero TIMEOUT still needs a legal one-bit counter even though it never expires.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] count_r;
  logic          expired_s;

  // Wait-cycle counter; saturates at expiry so it cannot wrap back to zero.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expired_s) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry decode.
  always_comb begin
    if (TIMEOUT == 0) begin
      expired_s = 1'b0;
    end else begin
      expired_s = (count_r == CW'(TIMEOUT));
    end
  end

  assign expired = expired_s;

endmodule

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a command/response handshake into AW/W/B or AR/R traffic.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  state_r, state_s;
  logic                    cmd_wr_r, cmd_wr_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic [STRB_WIDTH-1:0]   wstrb_r, wstrb_s;
  logic                    awvalid_r, awvalid_s;
  logic                    wvalid_r, wvalid_s;
  logic                    bready_r, bready_s;
  logic                    arvalid_r, arvalid_s;
  logic                    rready_r, rready_s;
  logic                    cmd_ready_r, cmd_ready_s;
  logic                    rsp_valid_r, rsp_valid_s;
  logic                    rsp_timeout_r, rsp_timeout_s;
  logic [1:0]              rsp_resp_r, rsp_resp_s;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic                    timer_clear_s;
  logic                    timer_enable_s;
  logic                    timer_expired_s;

  axi4_lite_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .clear   (timer_clear_s),
    .enable  (timer_enable_s),
    .expired (timer_expired_s)
  );

  // State and all output registers; every AXI/response output comes straight from a flop.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r       <= ST_IDLE;
      cmd_wr_r      <= 1'b0;
      addr_r        <= '0;
      wdata_r       <= '0;
      wstrb_r       <= '0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      cmd_ready_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_resp_r    <= 2'b00;
      rsp_rdata_r   <= '0;
    end else begin
      state_r       <= state_s;
      cmd_wr_r      <= cmd_wr_s;
      addr_r        <= addr_s;
      wdata_r       <= wdata_s;
      wstrb_r       <= wstrb_s;
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      bready_r      <= bready_s;
      arvalid_r     <= arvalid_s;
      rready_r      <= rready_s;
      cmd_ready_r   <= cmd_ready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_timeout_r <= rsp_timeout_s;
      rsp_resp_r    <= rsp_resp_s;
      rsp_rdata_r   <= rsp_rdata_s;
    end
  end

  // Next-state and next-output decode; outputs are computed for the coming state, then registered.
  always_comb begin
    state_s        = state_r;
    cmd_wr_s       = cmd_wr_r;
    addr_s         = addr_r;
    wdata_s        = wdata_r;
    wstrb_s        = wstrb_r;
    awvalid_s      = awvalid_r;
    wvalid_s       = wvalid_r;
    bready_s       = bready_r;
    arvalid_s      = arvalid_r;
    rready_s       = rready_r;
    cmd_ready_s    = cmd_ready_r;
    rsp_valid_s    = rsp_valid_r;
    rsp_timeout_s  = rsp_timeout_r;
    rsp_resp_s     = rsp_resp_r;
    rsp_rdata_s    = rsp_rdata_r;
    timer_clear_s  = 1'b0;
    timer_enable_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (cmd_valid && cmd_ready_r) begin
          cmd_ready_s = 1'b0;
          cmd_wr_s    = cmd_wr;
          addr_s      = cmd_addr;
          wdata_s     = cmd_wdata;
          wstrb_s     = cmd_wstrb;
          if (cmd_wr) begin
            state_s   = ST_WRITE;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
          end else begin
            state_s   = ST_RADDR;
            arvalid_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // AW and W retire independently; leave only once both are done.
        if (awvalid_r && AWREADY) begin
          awvalid_s = 1'b0;
        end else begin
          awvalid_s = awvalid_r;
        end
        if (wvalid_r && WREADY) begin
          wvalid_s = 1'b0;
        end else begin
          wvalid_s = wvalid_r;
        end
        if (!awvalid_s && !wvalid_s) begin
          state_s       = ST_WRESP;
          bready_s      = 1'b1;
          timer_clear_s = 1'b1;
        end else begin
          state_s = ST_WRITE;
        end
      end

      ST_WRESP: begin
        // A B handshake in the expiry cycle still wins over the timeout.
        if (BVALID && bready_r) begin
          state_s     = ST_RSP;
          bready_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_resp_s  = BRESP;
          rsp_rdata_s = '0;
        end else if (timer_expired_s) begin
          state_s       = ST_RSP;
          bready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_timeout_s = 1'b1;
          rsp_resp_s    = AXI_RESP_SLVERR;
          rsp_rdata_s   = '0;
        end else begin
          timer_enable_s = 1'b1;
        end
      end

      ST_RADDR: begin
        if (ARREADY) begin
          state_s       = ST_RDATA;
          arvalid_s     = 1'b0;
          rready_s      = 1'b1;
          timer_clear_s = 1'b1;
        end else begin
          state_s = ST_RADDR;
        end
      end

      ST_RDATA: begin
        if (RVALID && rready_r) begin
          state_s     = ST_RSP;
          rready_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_resp_s  = RRESP;
          rsp_rdata_s = RDATA;
        end else if (timer_expired_s) begin
          state_s       = ST_RSP;
          rready_s      = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_timeout_s = 1'b1;
          rsp_resp_s    = AXI_RESP_SLVERR;
          rsp_rdata_s   = '0;
        end else begin
          timer_enable_s = 1'b1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          if (rsp_timeout_r) begin
            // The slave still owes a response; reopen its channel to swallow it.
            state_s  = ST_DRAIN;
            bready_s = cmd_wr_r;
            rready_s = !cmd_wr_r;
          end else begin
            state_s     = ST_IDLE;
            cmd_ready_s = 1'b1;
          end
        end else begin
          state_s = ST_RSP;
        end
      end

      ST_DRAIN: begin
        if ((cmd_wr_r && BVALID) || (!cmd_wr_r && RVALID)) begin
          state_s       = ST_IDLE;
          bready_s      = 1'b0;
          rready_s      = 1'b0;
          rsp_timeout_s = 1'b0;
          cmd_ready_s   = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end

      default: begin
        state_s       = ST_IDLE;
        awvalid_s     = 1'b0;
        wvalid_s      = 1'b0;
        bready_s      = 1'b0;
        arvalid_s     = 1'b0;
        rready_s      = 1'b0;
        cmd_ready_s   = 1'b0;
        rsp_valid_s   = 1'b0;
        rsp_timeout_s = 1'b0;
      end
    endcase
  end

  assign cmd_ready   = cmd_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_resp    = rsp_resp_r;
  assign rsp_timeout = rsp_timeout_r;
  assign AWADDR      = addr_r;
  assign AWVALID     = awvalid_r;
  assign WDATA       = wdata_r;
  assign WSTRB       = wstrb_r;
  assign WVALID      = wvalid_r;
  assign BREADY      = bready_r;
  assign ARADDR      = addr_r;
  assign ARVALID     = arvalid_r;
  assign RREADY      = rready_r;

endmodule
